// File: rtl/idct_writeback.sv
// Writes one 8x8 block of S values (from the shared DPRAM) into the SRAM frame buffer.
// Each S value is scaled by 2^-16 and clipped to 0..255; pixel pairs are packed into 16-bit words.
module idct_writeback #(
  parameter logic [6:0]  S_BASE       = 7'd0,
  parameter logic [17:0] Y_BASE       = 18'd0,
  parameter logic [17:0] U_BASE       = 18'd38400,
  parameter logic [17:0] V_BASE       = 18'd57600,
  parameter logic [17:0] Y_ROW_WORDS  = 18'd160,
  parameter logic [17:0] UV_ROW_WORDS = 18'd80
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        WB_start,
  output logic        WB_done,
  output logic        WB_busy,
  input  logic [1:0]  plane,
  input  logic [4:0]  block_row,
  input  logic [5:0]  block_col,
  output logic [6:0]  S_read_address,
  input  logic [31:0] S_read_data,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  rd_cnt_q, rd_cnt_d;
  logic [5:0]  cap_k_q, cap_k_d;
  logic        cap_valid_q, cap_valid_d;
  logic [1:0]  plane_q, plane_d;
  logic [4:0]  brow_q, brow_d;
  logic [5:0]  bcol_q, bcol_d;
  logic [7:0]  hi_q, hi_d;
  logic [6:0]  rd_addr_q, rd_addr_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_n_q, we_n_d;

  logic [7:0]  pix;
  logic [17:0] plane_base;
  logic [17:0] row_words;
  logic [17:0] row_idx;
  logic [17:0] word_addr;
  logic        s_frac_unused;

  // Fractional bits are discarded by the >>>16 scaling.
  assign s_frac_unused = ^S_read_data[15:0];

  always_comb begin
    if (S_read_data[31])          pix = 8'd0;
    else if (|S_read_data[30:24]) pix = 8'd255;
    else                          pix = S_read_data[23:16];
  end

  always_comb begin
    case (plane_q)
      2'd0:    begin plane_base = Y_BASE; row_words = Y_ROW_WORDS;  end
      2'd1:    begin plane_base = U_BASE; row_words = UV_ROW_WORDS; end
      default: begin plane_base = V_BASE; row_words = UV_ROW_WORDS; end
    endcase
    row_idx   = 18'({brow_q, 3'b000}) + 18'(cap_k_q[5:3]);
    word_addr = plane_base + row_idx * row_words + 18'({bcol_q, 2'b00}) + 18'(cap_k_q[2:1]);
  end

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    cap_k_d     = cap_k_q;
    cap_valid_d = 1'b0;
    plane_d     = plane_q;
    brow_d      = brow_q;
    bcol_d      = bcol_q;
    hi_d        = hi_q;
    rd_addr_d   = rd_addr_q;
    sram_addr_d = sram_addr_q;
    wdata_d     = wdata_q;
    we_n_d      = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (WB_start) begin
          plane_d   = plane;
          brow_d    = block_row;
          bcol_d    = block_col;
          rd_cnt_d  = 6'd0;
          rd_addr_d = S_BASE;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        // Tag the read issued this cycle so its data is processed next cycle.
        cap_valid_d = 1'b1;
        cap_k_d     = rd_cnt_q;
        if (rd_cnt_q == 6'd63) begin
          rd_cnt_d = 6'd0;
          state_d  = S_DRAIN;
        end else begin
          rd_cnt_d  = rd_cnt_q + 6'd1;
          rd_addr_d = S_BASE + {1'b0, rd_cnt_q + 6'd1};
        end
      end
      S_DRAIN: begin
        if (!we_n_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (cap_valid_q) begin
      if (!cap_k_q[0]) begin
        hi_d = pix;
      end else begin
        we_n_d      = 1'b0;
        wdata_d     = {hi_q, pix};
        sram_addr_d = word_addr;
      end
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= 6'd0;
      cap_k_q     <= 6'd0;
      cap_valid_q <= 1'b0;
      plane_q     <= 2'd0;
      brow_q      <= 5'd0;
      bcol_q      <= 6'd0;
      hi_q        <= 8'd0;
      rd_addr_q   <= S_BASE;
      sram_addr_q <= 18'd0;
      wdata_q     <= 16'd0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      cap_k_q     <= cap_k_d;
      cap_valid_q <= cap_valid_d;
      plane_q     <= plane_d;
      brow_q      <= brow_d;
      bcol_q      <= bcol_d;
      hi_q        <= hi_d;
      rd_addr_q   <= rd_addr_d;
      sram_addr_q <= sram_addr_d;
      wdata_q     <= wdata_d;
      we_n_q      <= we_n_d;
    end
  end

  assign WB_done         = (state_q == S_DONE);
  assign WB_busy         = (state_q != S_IDLE);
  assign S_read_address  = rd_addr_q;
  assign SRAM_address    = sram_addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;

endmodule

// File: tb/tb_idct_writeback.sv
// Directed bench for idct_writeback: a DPRAM model feeds S values, SRAM writes are
// captured per cycle and compared against hand values and a pixel/address model.
module tb_idct_writeback;

  logic        clk;
  logic        rst_n;
  logic        wb_start;
  logic        wb_done;
  logic        wb_busy;
  logic [1:0]  plane;
  logic [4:0]  block_row;
  logic [5:0]  block_col;
  logic [6:0]  s_read_address;
  logic [31:0] s_read_data;
  logic [17:0] sram_address;
  logic [15:0] sram_write_data;
  logic        sram_we_n;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:127];
  logic [33:0] exp_q[$];
  logic [17:0] got_addr[$];
  logic [15:0] got_data[$];
  int          got_cyc[$];
  int          done_cnt;
  int          done_cyc;
  int          busy_bad;

  idct_writeback dut (
    .CLOCK_50_I     (clk),
    .Resetn         (rst_n),
    .WB_start       (wb_start),
    .WB_done        (wb_done),
    .WB_busy        (wb_busy),
    .plane          (plane),
    .block_row      (block_row),
    .block_col      (block_col),
    .S_read_address (s_read_address),
    .S_read_data    (s_read_data),
    .SRAM_address   (sram_address),
    .SRAM_write_data(sram_write_data),
    .SRAM_we_n      (sram_we_n)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Synchronous-read DPRAM model
  always @(posedge clk) s_read_data <= mem[s_read_address];

  function automatic logic [7:0] pix_model(input logic [31:0] s);
    int v;
    v = $signed(s) >>> 16;
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  task automatic fill_mem(input logic [31:0] seed_val);
    for (int i = 0; i < 128; i++) mem[i] = seed_val;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 128; i++) mem[i] = {$urandom_range(0, 65535), $urandom_range(0, 65535)}[31:0];
  endtask

  // Runs one block from cycle 0 (start cycle) to cycle 75; optional re-pulse cycle and reset cycle.
  task automatic run_block(input logic [1:0] pl, input logic [4:0] br, input logic [5:0] bc,
                           input int repulse_cyc, input int reset_cyc);
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    busy_bad = 0;
    @(negedge clk);
    plane = pl;
    block_row = br;
    block_col = bc;
    wb_start = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 75; cyc++) begin
      if (cyc == reset_cyc) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (sram_we_n !== 1'b1 || wb_busy !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_op: we_n=%b busy=%b required we_n=1 busy=0", sram_we_n, wb_busy);
        end
        wb_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (!sram_we_n) begin
        got_addr.push_back(sram_address);
        got_data.push_back(sram_write_data);
        got_cyc.push_back(cyc);
      end
      if (wb_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (wb_busy !== (cyc <= 67)) busy_bad++;
      wb_start = (cyc + 1 == repulse_cyc);
      @(negedge clk);
    end
    wb_start = 1'b0;
  endtask

  // Compares every captured write of the last block against the model.
  task automatic compare_block(input string name, input logic [1:0] pl, input logic [4:0] br,
                               input logic [5:0] bc);
    int base, rw, a, n;
    logic [33:0] e;
    base = (pl == 2'd0) ? 0 : (pl == 2'd1) ? 38400 : 57600;
    rw   = (pl == 2'd0) ? 160 : 80;
    exp_q.delete();
    for (int w = 0; w < 32; w++) begin
      a = base + (8 * int'(br) + w / 4) * rw + 4 * int'(bc) + (w % 4);
      e = {a[17:0], pix_model(mem[2*w]), pix_model(mem[2*w+1])};
      exp_q.push_back(e);
    end
    n = got_addr.size();
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL %s write_count: got %0d required 32", name, n);
    end
    for (int w = 0; w < 32 && w < n; w++) begin
      e = exp_q.pop_front();
      checks++;
      if ({got_addr[w], got_data[w]} !== e || got_cyc[w] != 2 * w + 4) begin
        errors++;
        $display("FAIL %s write%0d: addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                 name, w, got_addr[w], got_data[w], got_cyc[w], e[33:16], e[15:0], 2 * w + 4);
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 67) begin
      errors++;
      $display("FAIL %s done: count=%0d cyc=%0d required count=1 cyc=67", name, done_cnt, done_cyc);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s busy_window: %0d bad cycles required 0", name, busy_bad);
    end
  endtask

  task automatic check_addr(input string name, input int idx, input logic [17:0] required);
    checks++;
    if (idx >= got_addr.size()) begin
      errors++;
      $display("FAIL %s: no write %0d required addr %0d", name, idx, required);
    end else if (got_addr[idx] !== required) begin
      errors++;
      $display("FAIL %s: addr %0d required %0d", name, got_addr[idx], required);
    end
  endtask

  task automatic check_data(input string name, input int idx, input logic [15:0] required);
    checks++;
    if (idx >= got_data.size()) begin
      errors++;
      $display("FAIL %s: no write %0d required data %h", name, idx, required);
    end else if (got_data[idx] !== required) begin
      errors++;
      $display("FAIL %s: data %h required %h", name, got_data[idx], required);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wb_start = 1'b0;
    plane = 2'd0;
    block_row = 5'd0;
    block_col = 6'd0;
    fill_mem(32'd0);
    repeat (2) @(negedge clk);
    checks++;
    if (wb_done !== 1'b0 || wb_busy !== 1'b0 || sram_we_n !== 1'b1 || sram_address !== 18'd0 ||
        sram_write_data !== 16'd0 || s_read_address !== 7'd0) begin
      errors++;
      $display("FAIL reset_values: done=%b busy=%b we_n=%b addr=%0d data=%h raddr=%0d required 0 0 1 0 0000 0",
               wb_done, wb_busy, sram_we_n, sram_address, sram_write_data, s_read_address);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_block();
    fill_mem(32'd0);
    run_block(2'd0, 5'd0, 6'd0, 0, 0);
    compare_block("zero_block", 2'd0, 5'd0, 6'd0);
    check_addr("zero_addr0", 0, 18'd0);
    check_addr("zero_addr3", 3, 18'd3);
    check_addr("zero_addr4", 4, 18'd160);
    check_addr("zero_addr31", 31, 18'd1123);
    check_data("zero_data17", 17, 16'h0000);
  endtask

  task automatic test_packing();
    fill_random();
    mem[0] = 32'h0080_0000;
    mem[1] = 32'h00FF_0000;
    mem[2] = 32'h0000_FFFF;
    mem[3] = 32'h0001_0000;
    run_block(2'd0, 5'd0, 6'd0, 0, 0);
    compare_block("packing", 2'd0, 5'd0, 6'd0);
    check_data("pack_word0", 0, 16'h80FF);
    check_data("pack_word1", 1, 16'h0001);
  endtask

  task automatic test_clipping();
    fill_random();
    mem[0] = 32'hFFFF_0000;
    mem[1] = 32'h0100_0000;
    mem[2] = 32'h8000_0000;
    mem[3] = 32'h7FFF_FFFF;
    mem[4] = 32'h00FF_FFFF;
    mem[5] = 32'hFFFF_FFFF;
    run_block(2'd0, 5'd3, 6'd5, 0, 0);
    compare_block("clipping", 2'd0, 5'd3, 6'd5);
    check_data("clip_neg_over", 0, 16'h00FF);
    check_data("clip_extremes", 1, 16'h00FF);
    check_data("clip_edge", 2, 16'hFF00);
  endtask

  task automatic test_addressing();
    fill_random();
    run_block(2'd0, 5'd29, 6'd39, 0, 0);
    compare_block("y_corner", 2'd0, 5'd29, 6'd39);
    check_addr("y_corner_first", 0, 18'd37276);
    check_addr("y_corner_last", 31, 18'd38399);
    run_block(2'd1, 5'd0, 6'd19, 0, 0);
    compare_block("u_block", 2'd1, 5'd0, 6'd19);
    check_addr("u_first", 0, 18'd38476);
    run_block(2'd2, 5'd1, 6'd0, 0, 0);
    compare_block("v_block", 2'd2, 5'd1, 6'd0);
    check_addr("v_first", 0, 18'd58240);
    run_block(2'd3, 5'd1, 6'd0, 0, 0);
    check_addr("plane3_as_v", 0, 18'd58240);
  endtask

  task automatic test_restart_ignored();
    fill_random();
    run_block(2'd0, 5'd2, 6'd7, 30, 0);
    compare_block("repulse_30", 2'd0, 5'd2, 6'd7);
    // A start during the done cycle must not launch another block.
    run_block(2'd1, 5'd4, 6'd3, 67, 0);
    compare_block("repulse_done", 2'd1, 5'd4, 6'd3);
  endtask

  task automatic test_reset_mid_block();
    fill_random();
    run_block(2'd0, 5'd0, 6'd0, 0, 20);
    checks++;
    if (got_addr.size() != 8) begin
      errors++;
      $display("FAIL partial_writes: got %0d required 8", got_addr.size());
    end
    run_block(2'd2, 5'd6, 6'd11, 0, 0);
    compare_block("after_reset", 2'd2, 5'd6, 6'd11);
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_block(2'd0, 5'd10, 6'd20, 0, 0);
    compare_block("b2b_first", 2'd0, 5'd10, 6'd20);
    fill_random();
    run_block(2'd1, 5'd11, 6'd1, 0, 0);
    compare_block("b2b_second", 2'd1, 5'd11, 6'd1);
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_packing();
    test_clipping();
    test_addressing();
    test_restart_ignored();
    test_reset_mid_block();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idct_writeback.md
Name: idct_writeback

Overview:
Downstream stage of the matrix multiplier. After the S pass (S = T·Cᵀ) has written 64 32-bit signed S values into the shared dual-port RAM, this block reads them in row-major order. It scales and clips each value to an 8-bit pixel, packs pixel pairs into 16-bit words, and writes one 8x8 block into the external SRAM frame buffer (Y, U or V plane). It runs one block per WB_start pulse and signals WB_done.

Parameters:
S_BASE, 7'd0, DPRAM word address of S[0][0]; S[r][c] is at S_BASE + 8r + c.
Y_BASE, 18'd0, SRAM word address of the Y plane.
U_BASE, 18'd38400, SRAM word address of the U plane.
V_BASE, 18'd57600, SRAM word address of the V plane.
Y_ROW_WORDS, 18'd160, 16-bit words per Y image row (320 px).
UV_ROW_WORDS, 18'd80, 16-bit words per U/V image row (160 px).

Ports:
CLOCK_50_I  input  1  50 MHz system clock, rising edge.
Resetn  input  1  asynchronous active-low reset.
WB_start  input  1  single-cycle request to write back one block.
WB_done  output  1  single-cycle pulse when the block's last SRAM write has completed.
WB_busy  output  1  high from start acceptance until the done cycle, inclusive.
plane  input  2  0=Y, 1=U, 2=V, 3 treated as V; sampled at start.
block_row  input  5  block row index (0..29); sampled at start.
block_col  input  6  block column index (Y 0..39, U/V 0..19); sampled at start.
S_read_address  output  7  DPRAM read address.
S_read_data  input  32  DPRAM read data, valid one cycle after the address.
SRAM_address  output  18  SRAM word address.
SRAM_write_data  output  16  packed pixel pair: even column in [15:8], odd column in [7:0].
SRAM_we_n  output  1  active-low SRAM write enable.

Behaviour:
- Clock and reset: one clock, CLOCK_50_I; Resetn is asynchronous and active-low.
- Reset values: state=IDLE, WB_done=0, WB_busy=0, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, S_read_address=S_BASE, all counters=0.
- States:
  - IDLE: on WB_start, latch plane/block_row/block_col, set WB_busy, go to READ.
  - READ: issue 64 reads. Read k (k=0..63) is issued in cycle k+1, where cycle 0 is the start-acceptance cycle.
  - DRAIN: wait for the last write to finish.
  - DONE: pulse WB_done for one cycle, clear WB_busy, return to IDLE.
- Data timing: data for read k is captured at the end of cycle k+2.
- Pixel conversion: p = S >>> 16 (arithmetic shift, truncation toward −inf).
  - p < 0 gives 0.
  - p > 255 gives 255.
  - otherwise p[7:0].
- Packing:
  - even k: pixel held in the high-byte register.
  - odd k: the word is formed, and in cycle k+3 SRAM_we_n=0 with address and data valid. This gives writes in cycles 4,6,…,66 (32 writes, we_n low exactly one cycle each).
- SRAM address for the word holding row r, columns c and c+1 (c even):
  - address = plane_base + (8·block_row + r)·row_words + 4·block_col + c/2.
  - plane_base and row_words are selected by the latched plane.
  - Computed in unsigned 18-bit arithmetic; overflow wraps silently.
  - Coordinate range is the caller's responsibility.
- Latency: WB_done is asserted in cycle 67. WB_busy is high during cycles 1..67. The next WB_start is accepted no earlier than cycle 68.
- WB_start while busy: ignored (no queueing). Latched inputs must not change mid-block.
- S_read_address: holds its last value outside READ. The DPRAM read has no side effects.
- Reset mid-operation: immediate return to IDLE, SRAM_we_n=1. A partially written block is not completed.
- WB_start is sampled only in IDLE. WB_start in the DONE cycle is ignored.

Test Plan:
- S all 0x00000000, plane=0, block (0,0) -> 32 writes of 0x0000. Addresses in write order: 0,1,2,3,160,161,…,1123. WB_done in cycle 67 only.
- S[0][0]=0x00800000, S[0][1]=0x00FF0000 -> first write data 0x80FF at address Y_BASE. S[0][2]=0x0000FFFF, S[0][3]=0x00010000 -> second write 0x0001.
- Clipping: S=0xFFFF0000 (−1) packed with S=0x01000000 (256) -> 0x00FF. S=0x80000000 packed with S=0x7FFFFFFF -> 0x00FF.
- Addressing:
  - Y block (29,39): first address 37276, last address 38399.
  - U block (0,19): first address 38476.
  - V block (1,0): first address 57600+640=58240.
- WB_start re-pulsed at cycle 30 -> ignored, still exactly 32 writes. Reset asserted at cycle 20 -> SRAM_we_n=1 and WB_busy=0 immediately. A new start after reset produces a full, correct block.
